// File: rtl/b_muxn_seq.sv
// b_muxn_seq: registered N-way channel mux with a manual-select mode and an
// auto-scan mode. Output side uses a valid/ready handshake with a stall hold.
// Scan mode dwells DWELL accepted outputs on each channel before advancing.
// Optional feature: define B_MUXN_PARITY_EN to add the y_par output, which is
// the even parity of the loaded data.
module b_muxn_seq #(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int DWELL    = 4,
    localparam int SW      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   i,
    input  logic [SW-1:0]    s,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     y,
    output logic [SW-1:0]    y_sel,
    output logic             y_vld,
    input  logic             y_rdy,
    output logic             y_err
`ifdef B_MUXN_PARITY_EN
    ,
    output logic             y_par
`endif
);

    // SW+1 bits so that N itself (e.g. 16) is representable for the range test
    localparam logic [SW:0] NV = (SW+1)'(N);

    typedef enum logic {MAN = 1'b0, SCAN = 1'b1} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_sel_q;
    logic [7:0]      r_dcnt;
    logic [W-1:0]    r_y;
    logic [SW-1:0]   r_y_sel;
    logic            r_y_vld;
    logic            r_y_err;

    logic            w_load;
    logic            w_s_ok;
    logic [W-1:0]    w_man_data;
    logic [W-1:0]    w_scan_data;
    logic [W-1:0]    w_ld_data;
    logic [SW-1:0]   w_ld_sel;
    logic            w_ld_err;
    logic [7:0]      w_dcnt_inc;
    logic            w_dwell_done;
    logic [SW-1:0]   w_sel_adv;

    // A new sample is taken whenever enabled and the output slot is free or draining
    assign w_load = en && (!r_y_vld || y_rdy);
    assign w_s_ok = {1'b0, s} < NV;

    // Channel muxes; loops only cover legal channels so an out-of-range select reads 0
    always_comb begin
        w_man_data  = '0;
        w_scan_data = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SW'(k))       w_man_data  = i[k*W +: W];
            if (r_sel_q == SW'(k)) w_scan_data = i[k*W +: W];
        end
    end

    // Load source follows the current state, not the mode input, so transition
    // edges still load with the old state's rules
    assign w_ld_data  = (r_state == MAN) ? (w_s_ok ? w_man_data : '0) : w_scan_data;
    assign w_ld_sel   = (r_state == MAN) ? s : r_sel_q;
    assign w_ld_err   = (r_state == MAN) && !w_s_ok;

    assign w_dcnt_inc   = r_dcnt + 8'd1;
    assign w_dwell_done = (w_dcnt_inc == 8'(DWELL));
    assign w_sel_adv    = (r_sel_q == SW'(N-1)) ? '0 : r_sel_q + SW'(1);

`ifdef B_MUXN_PARITY_EN
    logic r_y_par;
`endif

    // Mode FSM, scan index/dwell counter and registered output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MAN;
            r_sel_q <= '0;
            r_dcnt  <= '0;
            r_y     <= '0;
            r_y_sel <= '0;
            r_y_vld <= 1'b0;
            r_y_err <= 1'b0;
`ifdef B_MUXN_PARITY_EN
            r_y_par <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_y     <= w_ld_data;
                r_y_sel <= w_ld_sel;
                r_y_err <= w_ld_err;
                r_y_vld <= 1'b1;
`ifdef B_MUXN_PARITY_EN
                r_y_par <= ^w_ld_data;
`endif
            end else if (y_rdy) begin
                r_y_vld <= 1'b0;
            end

            if (r_state == MAN) begin
                if (mode) begin
                    // Scan starts from the manual channel when it is legal
                    r_state <= SCAN;
                    r_sel_q <= w_s_ok ? s : '0;
                    r_dcnt  <= '0;
                end
            end else begin
                if (!mode) begin
                    // Leaving scan freezes index and dwell progress
                    r_state <= MAN;
                end else if (w_load) begin
                    if (w_dwell_done) begin
                        r_dcnt  <= '0;
                        r_sel_q <= w_sel_adv;
                    end else begin
                        r_dcnt  <= w_dcnt_inc;
                    end
                end
            end
        end
    end

    assign y     = r_y;
    assign y_sel = r_y_sel;
    assign y_vld = r_y_vld;
    assign y_err = r_y_err;
`ifdef B_MUXN_PARITY_EN
    assign y_par = r_y_par;
`endif

endmodule

// File: tb/tb_b_muxn_seq.sv
// Bench for b_muxn_seq: two instances (N=4/DWELL=2 and N=3/DWELL=3) share one
// stimulus stream and are compared every cycle against a behavioural model,
// plus directed scenarios with constant expectations.
module tb_b_muxn_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i;
    logic [1:0]  s;
    logic        mode, en, y_rdy;

    logic [3:0]  y4, y3;
    logic [1:0]  ys4, ys3;
    logic        v4, v3, e4, e3;
`ifdef B_MUXN_PARITY_EN
    logic        p4, p3;
`endif

    b_muxn_seq #(.N(4), .W(4), .DWELL(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i(i), .s(s), .mode(mode), .en(en),
        .y(y4), .y_sel(ys4), .y_vld(v4), .y_rdy(y_rdy), .y_err(e4)
`ifdef B_MUXN_PARITY_EN
        , .y_par(p4)
`endif
    );

    b_muxn_seq #(.N(3), .W(4), .DWELL(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i(i[11:0]), .s(s), .mode(mode), .en(en),
        .y(y3), .y_sel(ys3), .y_vld(v3), .y_rdy(y_rdy), .y_err(e3)
`ifdef B_MUXN_PARITY_EN
        , .y_par(p3)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = N4/DWELL2 instance, 1 = N3/DWELL3 instance
    int NN[2] = '{4, 3};
    int DW[2] = '{2, 3};
    int m_scan[2], m_sel[2], m_cnt[2], m_y[2], m_ys[2], m_v[2], m_e[2];

    function automatic int chan(input int iv, input int k);
        return (iv >> (4*k)) & 15;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_scan[d] = 0; m_sel[d] = 0; m_cnt[d] = 0;
            m_y[d] = 0; m_ys[d] = 0; m_v[d] = 0; m_e[d] = 0;
        end
    endtask

    task automatic model_step();
        int iv, ss;
        bit ld;
        iv = int'(i);
        ss = int'(s);
        for (int d = 0; d < 2; d++) begin
            ld = en && (m_v[d] == 0 || y_rdy);
            if (ld) begin
                if (m_scan[d] == 0) begin
                    m_ys[d] = ss;
                    m_y[d]  = (ss < NN[d]) ? chan(iv, ss) : 0;
                    m_e[d]  = (ss < NN[d]) ? 0 : 1;
                end else begin
                    m_ys[d] = m_sel[d];
                    m_y[d]  = chan(iv, m_sel[d]);
                    m_e[d]  = 0;
                end
                m_v[d] = 1;
            end else if (y_rdy) begin
                m_v[d] = 0;
            end
            if (m_scan[d] == 1 && mode && ld) begin
                m_cnt[d]++;
                if (m_cnt[d] == DW[d]) begin
                    m_cnt[d] = 0;
                    m_sel[d] = (m_sel[d] + 1) % NN[d];
                end
            end
            if (m_scan[d] == 0 && mode) begin
                m_sel[d] = (ss < NN[d]) ? ss : 0;
                m_cnt[d] = 0;
            end
            m_scan[d] = mode ? 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_y4"},   y4,  m_y[0]);
        chk({tag, "_sel4"}, ys4, m_ys[0]);
        chk({tag, "_vld4"}, v4,  m_v[0]);
        chk({tag, "_err4"}, e4,  m_e[0]);
        chk({tag, "_y3"},   y3,  m_y[1]);
        chk({tag, "_sel3"}, ys3, m_ys[1]);
        chk({tag, "_vld3"}, v3,  m_v[1]);
        chk({tag, "_err3"}, e3,  m_e[1]);
`ifdef B_MUXN_PARITY_EN
        chk({tag, "_par4"}, p4, $countones(m_y[0]) % 2);
        chk({tag, "_par3"}, p3, $countones(m_y[1]) % 2);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all("cyc");
    endtask

    // Asynchronous reset pulse: outputs must clear with no clock edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_y4", y4, 0);
        chk("rst_vld4", v4, 0);
        chk("rst_sel4", ys4, 0);
        chk("rst_err3", e3, 0);
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp34[4] = '{3, 10, 5, 13};
    int exp35[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int held;

    initial begin
        rst_n = 1'b0; i = '0; s = '0; mode = 1'b0; en = 1'b0; y_rdy = 1'b1;
        model_reset();
        do_reset();

        // Manual select walk over a fixed word
        i = 16'hD5A3; en = 1'b1; y_rdy = 1'b1; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            cyc();
            chk("man_y", y4, exp34[k]);
            chk("man_sel", ys4, k);
        end
        // Out-of-range manual select on the N=3 instance
        s = 2'd3;
        cyc();
        chk("oor_y", y3, 0);
        chk("oor_sel", ys3, 3);
        chk("oor_err", e3, 1);
        s = 2'd2;
        cyc();
        chk("inr_err", e3, 0);
        chk("inr_y", y3, 5);

        // Scan sequence with DWELL=2
        do_reset();
        mode = 1'b1; en = 1'b0; s = 2'd0; y_rdy = 1'b1;
        cyc();
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i = 16'($urandom);
            cyc();
            chk("scan_sel", ys4, exp35[k]);
        end

        // Stall mid-dwell, then resume with no channel skipped
        do_reset();
        mode = 1'b1; en = 1'b0; s = 2'd0; y_rdy = 1'b1;
        cyc();
        en = 1'b1; i = 16'($urandom);
        held = chan(int'(i), 0);
        cyc();
        y_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i = 16'($urandom); s = 2'($urandom);
            cyc();
            chk("stall_y", y4, held);
            chk("stall_sel", ys4, 0);
            chk("stall_vld", v4, 1);
        end
        y_rdy = 1'b1;
        cyc();
        chk("resume_sel0", ys4, 0);
        cyc();
        chk("resume_sel1", ys4, 1);

        // Scan starts at the manual channel; reset while stalled
        do_reset();
        mode = 1'b0; s = 2'd2; en = 1'b1; y_rdy = 1'b1;
        cyc();
        mode = 1'b1;
        cyc();
        cyc();
        chk("m2s_sel4", ys4, 2);
        chk("m2s_sel3", ys3, 2);
        y_rdy = 1'b0;
        cyc();
        cyc();
        do_reset();

`ifdef B_MUXN_PARITY_EN
        mode = 1'b0; en = 1'b1; y_rdy = 1'b1; i = 16'h0070; s = 2'd1;
        cyc();
        chk("par_ch1", p4, 1);
`endif

        // Randomized traffic with occasional mode flips and resets
        mode = 1'b0; y_rdy = 1'b1;
        for (int k = 0; k < 600; k++) begin
            i = 16'($urandom);
            s = 2'($urandom);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            en    = ($urandom_range(0, 3) != 0);
            y_rdy = ($urandom_range(0, 2) != 0);
            cyc();
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
